// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, polarity encodings and helpers for the VGA raster generator.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int DEF_H_VIS   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_VIS   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;
  localparam int DEF_PIX_DIV = 2;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic pix_tick;
    logic h_wrap;
    logic v_wrap;
  } vga_dbg_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs of the timing generator: positions, syncs, data enable and strobes.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic [HW-1:0] HPIXEL;
  logic [VW-1:0] VPIXEL;
  logic          VGA_HSYNC;
  logic          VGA_VSYNC;
  logic          VGA_DE;
  logic          LINE_START;
  logic          FRAME_START;

  modport master (
    output HPIXEL, VPIXEL, VGA_HSYNC, VGA_VSYNC, VGA_DE, LINE_START, FRAME_START
  );

  modport slave (
    input HPIXEL, VPIXEL, VGA_HSYNC, VGA_VSYNC, VGA_DE, LINE_START, FRAME_START
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync-window and visible-region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = DEF_H_VIS,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  localparam int TOTAL = VIS + FP + SYNC + BP,
  localparam int W     = clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_act,
  output logic         vis
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END  = W'(VIS);
  localparam logic [W-1:0] SYNC_BEG = W'(VIS + FP);
  localparam logic [W-1:0] SYNC_END = W'(VIS + FP + SYNC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // wrap is the terminal-count flag; the caller qualifies it with its own advance.
  assign wrap     = (cnt == LAST);
  assign sync_act = (cnt >= SYNC_BEG) && (cnt < SYNC_END);
  assign vis      = (cnt < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, H/V axis counters and registered outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter bit HS_POL  = SYNC_ACTIVE_LOW,
  parameter bit VS_POL  = SYNC_ACTIVE_LOW,
  parameter int PIX_DIV = DEF_PIX_DIV,
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW      = clog2(H_TOTAL),
  localparam int VW      = clog2(V_TOTAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  vga_timing_gen_if.master        vga,
  output vga_dbg_t                dbg
);

  if (H_VIS < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_VIS < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: every timing width and PIX_DIV must be at least 1");
  end

  localparam int             DW       = clog2(PIX_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          pix_tick;
  logic          pos_first;
  logic          v_inc;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_sync, v_sync;
  logic          h_vis, v_vis;

  logic [HW-1:0] hpixel_q;
  logic [VW-1:0] vpixel_q;
  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;

  assign pix_tick  = enable && (div_cnt == DIV_LAST);
  assign pos_first = (div_cnt == '0);
  assign v_inc     = h_wrap && pix_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .inc     (pix_tick),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .sync_act(h_sync),
    .vis     (h_vis)
  );

  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .inc     (v_inc),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .sync_act(v_sync),
    .vis     (v_vis)
  );

  // Outputs register the counter state each enabled clock, so every position is shown
  // for exactly PIX_DIV clocks and the strobes mark the first of them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hpixel_q      <= '0;
      vpixel_q      <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (enable) begin
      hpixel_q      <= h_cnt;
      vpixel_q      <= v_cnt;
      hsync_q       <= h_sync ? HS_POL : ~HS_POL;
      vsync_q       <= v_sync ? VS_POL : ~VS_POL;
      de_q          <= h_vis && v_vis;
      line_start_q  <= pos_first && (h_cnt == '0);
      frame_start_q <= pos_first && (h_cnt == '0) && (v_cnt == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vga.HPIXEL      = hpixel_q;
  assign vga.VPIXEL      = vpixel_q;
  assign vga.VGA_HSYNC   = hsync_q;
  assign vga.VGA_VSYNC   = vsync_q;
  assign vga.VGA_DE      = de_q;
  assign vga.LINE_START  = line_start_q;
  assign vga.FRAME_START = frame_start_q;

  assign dbg.pix_tick = pix_tick;
  assign dbg.h_wrap   = h_wrap;
  assign dbg.v_wrap   = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-timing instance plus a default 640x480 instance (PIX_DIV=1, HS_POL=1).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int SHW = clog2(16);
  localparam int SVW = clog2(8);
  localparam int DHW = clog2(800);
  localparam int DVW = clog2(525);

  typedef struct packed {
    logic [3:0] h;
    logic [2:0] v;
    logic de, hs, vs, ls, fs;
  } out_s_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic de, hs, vs, ls, fs;
  } out_d_t;

  typedef struct {
    bit     rst;
    bit     en;
    int     clks;
    out_s_t exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s = 1'b0, en_s = 1'b1;
  logic rst_d = 1'b0, en_d = 1'b1;
  bit   mon_s = 1'b0, mon_d = 1'b0;
  int   checks = 0, errors = 0;

  vga_timing_gen_if #(.HW(SHW), .VW(SVW)) vs_if ();
  vga_timing_gen_if #(.HW(DHW), .VW(DVW)) vd_if ();
  vga_dbg_t dbg_s, dbg_d;

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(2)
  ) dut_s (.clk(clk), .reset(rst_s), .enable(en_s), .vga(vs_if), .dbg(dbg_s));

  vga_timing_gen #(
    .HS_POL(1'b1), .PIX_DIV(1)
  ) dut_d (.clk(clk), .reset(rst_d), .enable(en_d), .vga(vd_if), .dbg(dbg_d));

  out_s_t dut_s_v;
  out_d_t dut_d_v;
  assign dut_s_v = {vs_if.HPIXEL, vs_if.VPIXEL, vs_if.VGA_DE, vs_if.VGA_HSYNC,
                    vs_if.VGA_VSYNC, vs_if.LINE_START, vs_if.FRAME_START};
  assign dut_d_v = {vd_if.HPIXEL, vd_if.VPIXEL, vd_if.VGA_DE, vd_if.VGA_HSYNC,
                    vd_if.VGA_VSYNC, vd_if.LINE_START, vd_if.FRAME_START};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_s_t mk(int h, int v, bit de, bit hs, bit vs, bit ls, bit fs);
    out_s_t r;
    r.h = 4'(h); r.v = 3'(v);
    r.de = de; r.hs = hs; r.vs = vs; r.ls = ls; r.fs = fs;
    return r;
  endfunction

  // Reference: the n-th enabled clock since reset shows position n/PIX_DIV in raster order.
  function automatic out_s_t model_s(int n);
    int p, h, v;
    bit first;
    p = n / 2;
    h = p % 16;
    v = (p / 16) % 8;
    first = (n % 2) == 0;
    return mk(h, v, (h < 8) && (v < 4), !(h >= 10 && h < 13), !(v >= 5 && v < 7),
              first && h == 0, first && h == 0 && v == 0);
  endfunction

  function automatic out_d_t model_d(int n);
    out_d_t r;
    int h, v;
    h = n % 800;
    v = (n / 800) % 525;
    r.h = 10'(h); r.v = 10'(v);
    r.de = (h < 640) && (v < 480);
    r.hs = (h >= 656) && (h < 752);
    r.vs = !((v >= 490) && (v < 492));
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  int     n_s = 0, n_d = 0;
  out_s_t m_s = mk(0, 0, 0, 1, 1, 0, 0);
  out_d_t m_d = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      n_s = 0;
      m_s = mk(0, 0, 0, 1, 1, 0, 0);
    end else if (en_s) begin
      m_s = model_s(n_s);
      n_s++;
    end else begin
      m_s.ls = 1'b0;
      m_s.fs = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_d) begin
    if (!rst_d) begin
      n_d = 0;
      m_d = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    end else if (en_d) begin
      m_d = model_d(n_d);
      n_d++;
    end else begin
      m_d.ls = 1'b0;
      m_d.fs = 1'b0;
    end
  end

  // scoreboard: every clock, both instances against the reference
  always @(posedge clk) begin
    #3;
    check("s_model", dut_s_v, m_s);
    check("d_model", dut_d_v, m_d);
  end

  // small-instance run-length / period monitor
  int s_cyc, s_hs_run, s_vs_run, s_de_run, s_last_ls, s_last_fs;
  logic [3:0] s_prev_h;
  logic [2:0] s_prev_v;
  bit s_prev_ok;
  always @(negedge clk) begin
    if (!mon_s) begin
      s_cyc = 0; s_hs_run = 0; s_vs_run = 0; s_de_run = 0;
      s_last_ls = -1; s_last_fs = -1; s_prev_ok = 0;
    end else begin
      s_cyc++;
      if (!vs_if.VGA_HSYNC) begin
        s_hs_run++;
        check("s_hs_pos", (vs_if.HPIXEL >= 10) && (vs_if.HPIXEL <= 12), 1);
      end else if (s_hs_run != 0) begin
        check("s_hs_width", s_hs_run, 6);
        s_hs_run = 0;
      end
      if (!vs_if.VGA_VSYNC) begin
        s_vs_run++;
        check("s_vs_pos", (vs_if.VPIXEL >= 5) && (vs_if.VPIXEL <= 6), 1);
      end else if (s_vs_run != 0) begin
        check("s_vs_width", s_vs_run, 64);
        s_vs_run = 0;
      end
      if (vs_if.VGA_DE) s_de_run++;
      else if (s_de_run != 0) begin
        check("s_de_width", s_de_run, 16);
        s_de_run = 0;
      end
      if (vs_if.LINE_START) begin
        if (s_last_ls >= 0) check("s_ls_period", s_cyc - s_last_ls, 32);
        s_last_ls = s_cyc;
      end
      if (vs_if.FRAME_START) begin
        check("s_fs_with_ls", vs_if.LINE_START, 1);
        if (s_last_fs >= 0) check("s_fs_period", s_cyc - s_last_fs, 256);
        s_last_fs = s_cyc;
      end
      if (s_prev_ok && vs_if.VPIXEL != s_prev_v) begin
        check("s_v_step_h_wrap", {s_prev_h, vs_if.HPIXEL}, {4'd15, 4'd0});
        if (s_prev_v == 3'd7) check("s_v_wrap", vs_if.VPIXEL, 0);
      end
      s_prev_h = vs_if.HPIXEL;
      s_prev_v = vs_if.VPIXEL;
      s_prev_ok = 1;
    end
  end

  // default-instance monitor
  int d_cyc, d_hs_run, d_de_run, d_last_ls, d_hs_runs, d_ls_periods;
  always @(negedge clk) begin
    if (!mon_d) begin
      d_cyc = 0; d_hs_run = 0; d_de_run = 0; d_last_ls = -1;
      d_hs_runs = 0; d_ls_periods = 0;
    end else begin
      d_cyc++;
      if (vd_if.VGA_HSYNC) begin
        d_hs_run++;
        check("d_hs_pos", (vd_if.HPIXEL >= 656) && (vd_if.HPIXEL <= 751), 1);
      end else if (d_hs_run != 0) begin
        check("d_hs_width", d_hs_run, 96);
        d_hs_runs++;
        d_hs_run = 0;
      end
      if (vd_if.VGA_DE) d_de_run++;
      else if (d_de_run != 0) begin
        check("d_de_width", d_de_run, 640);
        d_de_run = 0;
      end
      if (vd_if.LINE_START) begin
        if (d_last_ls >= 0) begin
          check("d_ls_period", d_cyc - d_last_ls, 800);
          d_ls_periods++;
        end
        d_last_ls = d_cyc;
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    rst_d = 1'b1;
    #1 mon_d = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [63:0] exp_q[$];

  initial begin
    vec_t tbl[12];
    int vs_low, hs_low, de_hi, ls_cnt, fs_cnt;
    bit found;
    logic [3:0] ph;

    tbl[0]  = '{1'b0, 1'b1, 5,   mk(0,  0, 0, 1, 1, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 1,   mk(0,  0, 1, 1, 1, 1, 1)};
    tbl[2]  = '{1'b1, 1'b1, 1,   mk(0,  0, 1, 1, 1, 0, 0)};
    tbl[3]  = '{1'b1, 1'b1, 1,   mk(1,  0, 1, 1, 1, 0, 0)};
    tbl[4]  = '{1'b1, 1'b1, 18,  mk(10, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{1'b1, 1'b1, 12,  mk(0,  1, 1, 1, 1, 1, 0)};
    tbl[6]  = '{1'b1, 1'b0, 7,   mk(0,  1, 1, 1, 1, 0, 0)};
    tbl[7]  = '{1'b1, 1'b1, 1,   mk(0,  1, 1, 1, 1, 0, 0)};
    tbl[8]  = '{1'b1, 1'b1, 127, mk(0,  5, 0, 1, 0, 1, 0)};
    tbl[9]  = '{1'b1, 1'b1, 96,  mk(0,  0, 1, 1, 1, 1, 1)};
    tbl[10] = '{1'b1, 1'b1, 1,   mk(0,  0, 1, 1, 1, 0, 0)};
    tbl[11] = '{1'b0, 1'b1, 1,   mk(0,  0, 0, 1, 1, 0, 0)};

    for (int i = 0; i < 12; i++) begin
      rst_s = tbl[i].rst;
      en_s  = tbl[i].en;
      repeat (tbl[i].clks) @(negedge clk);
      check($sformatf("tbl_%0d", i), dut_s_v, tbl[i].exp);
    end

    // two full frames from reset release
    rst_s = 1'b1; en_s = 1'b1;
    #1 mon_s = 1'b1;
    vs_low = 0; hs_low = 0; de_hi = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      vs_low += !vs_if.VGA_VSYNC;
      hs_low += !vs_if.VGA_HSYNC;
      de_hi  += vs_if.VGA_DE;
      ls_cnt += vs_if.LINE_START;
      fs_cnt += vs_if.FRAME_START;
    end
    #1 mon_s = 1'b0;
    check("frames_vs_low", vs_low, 128);
    check("frames_hs_low", hs_low, 96);
    check("frames_de_high", de_hi, 128);
    check("frames_ls_count", ls_cnt, 16);
    check("frames_fs_count", fs_cnt, 2);

    // enable drop on the first clock of HPIXEL=5
    found = 0;
    ph = vs_if.HPIXEL;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (vs_if.HPIXEL == 4'd5 && ph != 4'd5) found = 1;
      ph = vs_if.HPIXEL;
    end
    check("en_find_h5", found, 1);
    if (found) begin
      en_s = 1'b0;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        check("en_hold", dut_s_v, mk(5, 0, 1, 1, 1, 0, 0));
      end
      en_s = 1'b1;
      exp_q = '{64'd5, 64'd6, 64'd6, 64'd7};
      while (exp_q.size() > 0) begin
        @(negedge clk);
        check("en_resume_h", vs_if.HPIXEL, exp_q.pop_front());
      end
    end

    // asynchronous reset between edges at (9,3)
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (vs_if.HPIXEL == 4'd9 && vs_if.VPIXEL == 3'd3) found = 1;
    end
    check("arst_find_9_3", found, 1);
    if (found) begin
      #2 rst_s = 1'b0;
      #1 check("arst_immediate", dut_s_v, mk(0, 0, 0, 1, 1, 0, 0));
      repeat (2) @(negedge clk);
      rst_s = 1'b1;
      @(negedge clk);
      check("arst_restart", dut_s_v, mk(0, 0, 1, 1, 1, 1, 1));
      @(negedge clk);
      check("arst_restart_2nd", dut_s_v, mk(0, 0, 1, 1, 1, 0, 0));
    end

    // random enable / occasional reset, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      en_s  = ($urandom_range(0, 3) != 0);
      rst_s = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk);
    rst_s = 1'b1; en_s = 1'b1;

    while (d_cyc < 1850) @(negedge clk);
    check("d_hs_runs_seen", d_hs_runs, 2);
    check("d_ls_periods_seen", d_ls_periods, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
